// File: rtl/teamd_decrementer.sv
// Loadable down-counter / countdown timer: manual load and step-down in IDLE,
// or automatic run-down to zero with a one-cycle Done pulse.
module teamd_decrementer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic             Load,
    input  logic             Dec,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next, q_minus1;
    logic             borrow_reg, borrow_next;
    logic             wrap;

    // Ripple borrow chain of half-subtractors; the final borrow is set only for Q == 0.
    always_comb begin
        logic b;
        b        = 1'b1;
        q_minus1 = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            q_minus1[i] = q_reg[i] ^ b;
            b           = ~q_reg[i] & b;
        end
        wrap = b;
    end

    always_comb begin
        state_next  = state;
        q_next      = q_reg;
        borrow_next = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    q_next     = D;
                    state_next = S_COUNT;
                end else if (Load) begin
                    q_next = D;
                end else if (Dec) begin
                    q_next      = q_minus1;
                    borrow_next = wrap;
                end
            end
            S_COUNT: begin
                if (wrap) begin
                    state_next = S_DONE;
                end else begin
                    q_next = q_minus1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            q_reg      <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state      <= state_next;
            q_reg      <= q_next;
            borrow_reg <= borrow_next;
        end
    end

    assign Q      = q_reg;
    assign Zero   = (q_reg == '0);
    assign Borrow = borrow_reg;
    assign Busy   = (state != S_IDLE);
    assign Done   = (state == S_DONE);

endmodule
